// File: rtl/i2s_tx.sv
// I2S transmitter: mono 16-bit samples, with a one-entry holding buffer, sent on both
// LRCK slots. BCLK is divided down from clk; data and LRCK change on BCLK falling edges.
module i2s_tx #(
   parameter int SLEN      = 16,
   parameter int SLOT_BITS = 16,
   parameter int BCLK_HALF = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SLEN-1:0] sample_in,
   input  logic            valid,
   output logic            ready,
   output logic            i2s_bclk,
   output logic            i2s_lrck,
   output logic            i2s_sdata,
   output logic            underrun
);

   localparam int FRAME = 2 * SLOT_BITS;
   localparam int PW    = $clog2(FRAME);
   localparam int DW    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

   logic [DW-1:0]   div_q, div_d;
   logic            bclk_q, bclk_d;
   logic [PW-1:0]   p_q, p_d;
   logic [SLEN-1:0] hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic [SLEN-1:0] last_q, last_d;
   logic [SLEN-1:0] frame_q, frame_d;
   logic            lrck_q, lrck_d;
   logic            sdata_q, sdata_d;
   logic            underrun_q, underrun_d;

   logic            tick, shift, load, accept;
   logic [PW-1:0]   k;
   logic [SLEN-1:0] frame_sh;

   always_comb begin
      tick        = (div_q == DW'(BCLK_HALF - 1));
      shift       = tick && bclk_q;
      load        = shift && (p_q == PW'(FRAME - 1));
      accept      = valid && !hold_full_q;

      div_d       = tick ? '0 : div_q + 1'b1;
      bclk_d      = tick ? ~bclk_q : bclk_q;
      p_d         = p_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      last_d      = last_q;
      frame_d     = frame_q;
      lrck_d      = lrck_q;
      sdata_d     = sdata_q;
      underrun_d  = 1'b0;

      if (shift)
         p_d = load ? '0 : p_q + 1'b1;

      // An empty hold at frame start repeats the previous sample; no bypass from sample_in.
      if (load) begin
         if (hold_full_q) begin
            frame_d     = hold_q;
            last_d      = hold_q;
            hold_full_d = 1'b0;
         end else begin
            frame_d    = last_q;
            underrun_d = 1'b1;
         end
      end

      if (accept) begin
         hold_d      = sample_in;
         hold_full_d = 1'b1;
      end

      k        = (p_d >= PW'(SLOT_BITS)) ? p_d - PW'(SLOT_BITS) : p_d;
      frame_sh = frame_d << k;
      if (shift) begin
         sdata_d = (int'(k) < SLEN) ? frame_sh[SLEN-1] : 1'b0;
         // LRCK leads the slot by one bit.
         lrck_d  = (p_d >= PW'(SLOT_BITS - 1)) && (p_d <= PW'(FRAME - 2));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q       <= '0;
         bclk_q      <= 1'b0;
         p_q         <= PW'(FRAME - 1);
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         last_q      <= '0;
         frame_q     <= '0;
         lrck_q      <= 1'b0;
         sdata_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         div_q       <= div_d;
         bclk_q      <= bclk_d;
         p_q         <= p_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         last_q      <= last_d;
         frame_q     <= frame_d;
         lrck_q      <= lrck_d;
         sdata_q     <= sdata_d;
         underrun_q  <= underrun_d;
      end
   end

   assign ready     = !hold_full_q;
   assign i2s_bclk  = bclk_q;
   assign i2s_lrck  = lrck_q;
   assign i2s_sdata = sdata_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (16- and 24-bit slots); monitors rebuild frames from the
// bus and compare them against a per-instance queue of expected samples and underrun flags.
module tb_i2s_tx;

   localparam int BH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] smp0 = '0, smp1 = '0;
   logic        vld0 = 1'b0, vld1 = 1'b0;
   logic        rdy0, bclk0, lrck0, sd0, ur0;
   logic        rdy1, bclk1, lrck1, sd1, ur1;

   always #5 clk = ~clk;

   i2s_tx #(.SLEN(16), .SLOT_BITS(16), .BCLK_HALF(BH)) dut0 (
      .clk(clk), .rst(rst), .sample_in(smp0), .valid(vld0), .ready(rdy0),
      .i2s_bclk(bclk0), .i2s_lrck(lrck0), .i2s_sdata(sd0), .underrun(ur0));

   i2s_tx #(.SLEN(16), .SLOT_BITS(24), .BCLK_HALF(BH)) dut1 (
      .clk(clk), .rst(rst), .sample_in(smp1), .valid(vld1), .ready(rdy1),
      .i2s_bclk(bclk1), .i2s_lrck(lrck1), .i2s_sdata(sd1), .underrun(ur1));

   typedef struct {
      logic [15:0] smp;
      int          ur;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc;

   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor state, indexed by instance
   int          m_p[2], m_per[2], m_frm[2], m_ur[2], frames[2];
   bit          m_prev[2], m_st[2];
   logic [23:0] m_l[2], m_r[2];

   initial begin
      frames[0] = 0;
      frames[1] = 0;
   end

   task automatic mon(input int ch, input int sb, input logic bclk, input logic lrck,
                      input logic sd, input logic ur);
      exp_t        e;
      bit          got;
      logic [23:0] w;
      if (rst) begin
         m_p[ch] = 2*sb - 1; m_st[ch] = 0; m_prev[ch] = 0;
         m_ur[ch] = 0; m_per[ch] = 0; m_frm[ch] = 0;
         return;
      end
      m_per[ch]++;
      m_frm[ch]++;
      if (ur) m_ur[ch]++;
      if (bclk && !m_prev[ch]) begin
         if (m_p[ch] == 0) begin
            if (m_st[ch]) chk($sformatf("ch%0d frame_len", ch), m_frm[ch], 4*sb*BH);
            m_st[ch] = 1; m_frm[ch] = 0; m_l[ch] = '0; m_r[ch] = '0;
         end
         if (m_st[ch]) begin
            chk($sformatf("ch%0d bclk_period", ch), m_per[ch], 2*BH);
            chk($sformatf("ch%0d lrck p=%0d", ch, m_p[ch]), lrck,
                (m_p[ch] >= sb-1 && m_p[ch] <= 2*sb-2) ? 1 : 0);
            if (m_p[ch] < sb) m_l[ch] = {m_l[ch][22:0], sd};
            else              m_r[ch] = {m_r[ch][22:0], sd};
            if (m_p[ch] == 2*sb-1) begin
               got = 0;
               if (ch == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
               if (ch == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
               if (!got) begin
                  checks++; errors++;
                  $display("FAIL ch%0d unexpected frame: left %0h right %0h", ch, m_l[ch], m_r[ch]);
               end else begin
                  w = {e.smp, 8'h00} >> (24 - sb);
                  chk($sformatf("ch%0d left slot", ch), m_l[ch], w);
                  chk($sformatf("ch%0d right slot", ch), m_r[ch], w);
                  chk($sformatf("ch%0d underrun cycles", ch), m_ur[ch], e.ur);
               end
               m_ur[ch] = 0;
               frames[ch]++;
            end
         end
         m_per[ch] = 0;
      end else if (!bclk && m_prev[ch]) begin
         m_p[ch] = (m_p[ch] + 1) % (2*sb);
      end
      m_prev[ch] = bclk;
   endtask

   always @(negedge clk) begin
      mon(0, 16, bclk0, lrck0, sd0, ur0);
      mon(1, 24, bclk1, lrck1, sd1, ur1);
   end

   task automatic chk_rst_outputs();
      chk("ch0 rst bclk", bclk0, 0);  chk("ch0 rst lrck", lrck0, 0);
      chk("ch0 rst sdata", sd0, 0);   chk("ch0 rst underrun", ur0, 0);
      chk("ch0 rst ready", rdy0, 1);
      chk("ch1 rst bclk", bclk1, 0);  chk("ch1 rst lrck", lrck1, 0);
      chk("ch1 rst sdata", sd1, 0);   chk("ch1 rst underrun", ur1, 0);
      chk("ch1 rst ready", rdy1, 1);
   endtask

   // Called at a negedge: releases reset and checks BCLK rises at edge 4, falls at edge 8.
   task automatic release_and_check(input bit pushed);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bclk edge %0d", k), bclk0, (k >= BH && k < 2*BH) ? 1 : 0);
         if (k == 1) begin
            chk("ready after first accept", rdy0, pushed ? 0 : 1);
            vld0 = 1'b0;
            vld1 = 1'b0;
         end
      end
   endtask

   task automatic send0(input logic [15:0] s);
      bit done = 0;
      @(negedge clk);
      smp0 = s;
      vld0 = 1'b1;
      for (int t = 0; t < 2000 && !done; t++) begin
         if (rdy0) begin
            @(posedge clk);
            done = 1;
         end
         @(negedge clk);
      end
      vld0 = 1'b0;
      chk($sformatf("send %0h accepted", s), done, 1);
   endtask

   task automatic wait_frames(input int ch, input int n);
      int t = 0;
      while (frames[ch] < n && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("ch%0d reached frame %0d", ch, n), (frames[ch] >= n) ? 1 : 0, 1);
   endtask

   initial begin
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_rst_outputs();

      q0.push_back('{16'hA5C3, 0});
      q0.push_back('{16'hA5C3, 1});
      q1.push_back('{16'hFFFF, 0});
      q1.push_back('{16'hFFFF, 1});
      q1.push_back('{16'hFFFF, 1});
      q1.push_back('{16'hFFFF, 1});
      smp0 = 16'hA5C3; vld0 = 1'b1;
      smp1 = 16'hFFFF; vld1 = 1'b1;
      release_and_check(1);

      // back-to-back pair after frame 2 has loaded; 8001 stalls until the next load
      q0.push_back('{16'h1234, 0});
      q0.push_back('{16'h8001, 0});
      q0.push_back('{16'h8001, 1});
      q0.push_back('{16'h00FF, 0});
      wait_frames(0, 1);
      repeat (8) @(posedge clk);
      send0(16'h1234);
      send0(16'h8001);
      chk("8001 accept cycle", cyc, 521);

      // valid arrives exactly on the frame-load edge (1032) with hold empty
      while (cyc < 1031) @(negedge clk);
      smp0 = 16'h00FF;
      vld0 = 1'b1;
      chk("ready at load edge", rdy0, 1);
      @(posedge clk);
      @(negedge clk);
      vld0 = 1'b0;
      chk("ready after late accept", rdy0, 0);

      // hold a sample mid-frame, then reset: it must be discarded
      while (cyc < 1560) @(negedge clk);
      send0(16'h7777);
      while (cyc < 1680) @(negedge clk);
      chk("ready before reset", rdy0, 0);
      chk("ch0 queue drained", q0.size(), 0);
      chk("ch1 queue drained", q1.size(), 0);
      #2 rst = 1'b1;
      #1 chk_rst_outputs();
      q0.push_back('{16'h0000, 1});
      q1.push_back('{16'h0000, 1});
      repeat (2) @(negedge clk);
      release_and_check(0);

      wait_frames(0, 7);
      wait_frames(1, 5);
      chk("ch0 queue empty at end", q0.size(), 0);
      chk("ch1 queue empty at end", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Output end of the audio path. Accepts 16-bit signed samples from `effects_pipline` (`sample_out` side) through a valid/ready handshake.
- Serializes each sample onto an I2S bus (BCLK, LRCK, SDATA) that drives the board DAC.
- Mono source: each accepted sample is sent in both the left and right slots of one frame.
- Generates its own bit clock from the system clock.
- Single-entry holding buffer decouples the pipeline from frame timing. Underrun is flagged.

Parameters:
- SLEN, 16, sample width in bits.
- SLOT_BITS, 16, bits per channel slot. Must be >= SLEN. Slot bits past SLEN are zero padding.
- BCLK_HALF, 4, clk cycles per BCLK half-period. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_in  in  SLEN  sample to transmit, two's complement.
- valid  in  1  sample_in is valid.
- ready  out  1  holding register empty; a sample is accepted when valid && ready at posedge clk.
- i2s_bclk  out  1  I2S bit clock, registered.
- i2s_lrck  out  1  word select: 0 = left, 1 = right. Registered.
- i2s_sdata  out  1  serial data, MSB first. Registered.
- underrun  out  1  one-clk pulse when a frame starts with the holding register empty.

Behaviour:
- Reset (async, immediate): all outputs and internal state as follows.
  - Outputs: i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, underrun=0, ready=1.
  - Internal: div_cnt=0, frame position p=2*SLOT_BITS-1, hold empty, last_sample=0, shift register=0.
- Divider:
  - div_cnt increments each clk.
  - At BCLK_HALF-1, div_cnt wraps to 0 and i2s_bclk toggles.
  - BCLK period = 2*BCLK_HALF clk; frame = 4*SLOT_BITS*BCLK_HALF clk (256 at defaults).
- Shift event: the clk edge on which i2s_bclk toggles 1->0.
  - p advances modulo 2*SLOT_BITS.
  - i2s_sdata and i2s_lrck update on this same edge, so both change on BCLK falling edges only.
- First bclk rise comes BCLK_HALF clk edges after reset release. The first shift event (p -> 0) comes after 2*BCLK_HALF edges.
- Data mapping:
  - Left slot covers p=0..SLOT_BITS-1; right slot covers p=SLOT_BITS..2*SLOT_BITS-1.
  - Slot bit k = p mod SLOT_BITS.
  - i2s_sdata = frame_sample[SLEN-1-k] for k < SLEN, otherwise 0.
- LRCK (standard I2S one-bit lead):
  - i2s_lrck=1 for p in SLOT_BITS-1..2*SLOT_BITS-2.
  - i2s_lrck=0 for p = 2*SLOT_BITS-1 and for p in 0..SLOT_BITS-2.
- Frame load, on the shift event where p wraps to 0:
  - If hold is full: frame_sample <= hold, last_sample <= hold, hold is emptied.
  - Otherwise: frame_sample <= last_sample, and underrun=1 for exactly that clk cycle.
  - The MSB appears on i2s_sdata on the same edge.
- Handshake:
  - ready = !hold_full (from registered state, no combinational path from valid).
  - When valid && ready at a posedge, hold <= sample_in and hold becomes full.
  - While ready=0, the producer holds sample_in/valid. The block never drops an accepted sample.
- Simultaneous accept and frame load with hold empty:
  - Frame load sees empty hold → underrun; last_sample is repeated.
  - The newly accepted sample goes into hold for the next frame. No bypass.
- Reset mid-frame: the frame in flight is abandoned. The held sample is discarded. The bus restarts from the reset state.

Test Plan:
1. Assert rst mid-run → same cycle, outputs go to bclk=0, lrck=0, sdata=0, ready=1, underrun=0. After release, first bclk rise comes at edge 4 and first fall at edge 8 (defaults).
2. Push 16'hA5C3 before the first frame, defaults.
   - Left slot on sdata, MSB first, sampled at bclk rises: 1010010111000011; right slot identical.
   - lrck rises at p=15 and falls at p=31.
   - bclk period is 8 clk; no underrun.
3. Send no sample for frame 2 after step 2 → frame 2 repeats A5C3; underrun is high for exactly 1 clk at the p 31->0 edge.
4. Drive 16'h1234 then 16'h8001 back to back with valid held.
   - 1234 is accepted at once; ready=0 holds 8001 until the next frame load; 8001 is accepted the cycle after that load.
   - Frames carry 1234 then 8001, with no underrun.
5. SLOT_BITS=24, sample 16'hFFFF → each slot shows 16 ones then 8 zeros; lrck toggles at p=23 and p=47; frame = 384 clk.
6. valid rises on the exact frame-load cycle with hold empty, sample 16'h00FF → underrun pulse; the current frame carries last_sample; the next frame carries 00FF.
